dma_copy_engine: RTL and testbench

- Block-copy DMA engine that drives the DMA requester port of the memory controller (DMAEn/DMAWrEn/DMAAddr/DMAData in, DMAOut/DMAValid back).
- Configured by a start pulse carrying source, destination and length. It copies `len` words one at a time: it reads a word, holds it in a one-word buffer, then writes it.
- Sits directly upstream of the memory controller, competing with the CPU and accelerator ports through the controller's arbitration.

---
 rtl/dma_copy_engine.sv | 145 ++++++++++++++
 tb/tb_dma_copy_engine.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
// Block-copy DMA engine: reads one word, buffers it, writes it, repeated len times.
// Drives the DMA requester port of the memory controller; outputs depend only on registers.
module dma_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  DMAEn,
  output logic                  DMAWrEn,
  output logic [ADDR_WIDTH-1:0] DMAAddr,
  output logic [DATA_WIDTH-1:0] DMAData,
  input  logic [DATA_WIDTH-1:0] DMAOut,
  input  logic                  DMAValid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_srcAddr;
  logic [ADDR_WIDTH-1:0] r_dstAddr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_index;
  logic [DATA_WIDTH-1:0] r_buffer;
  logic                  r_aborted;
  logic [LEN_WIDTH-1:0]  w_indexInc;
  logic [ADDR_WIDTH-1:0] w_indexAddr;
  logic                  w_inRequest;
  logic                  w_takeAbort;

  assign w_indexInc  = r_index + LEN_WIDTH'(1);
  assign w_indexAddr = ADDR_WIDTH'(r_index);
  assign w_inRequest = (r_state == RD_REQ) || (r_state == WR_REQ);
  assign w_takeAbort = w_inRequest && abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Abort outranks a coincident DMAValid for the state change; the write still counts below.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (len == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (DMAValid) begin
          w_nextState = WR_REQ;
        end
      end
      WR_REQ: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (DMAValid) begin
          w_nextState = (w_indexInc == r_len) ? FINISH : RD_REQ;
        end
      end
      FINISH: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The word index doubles as the completed-write count, so one counter serves both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srcAddr <= '0;
      r_dstAddr <= '0;
      r_len     <= '0;
      r_index   <= '0;
      r_buffer  <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_takeAbort;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_srcAddr <= src_addr;
            r_dstAddr <= dst_addr;
            r_len     <= len;
            r_index   <= '0;
          end
        end
        RD_REQ: begin
          if (DMAValid) begin
            r_buffer <= DMAOut;
          end
        end
        WR_REQ: begin
          if (DMAValid) begin
            r_index <= w_indexInc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy       = w_inRequest;
    done       = (r_state == FINISH);
    aborted    = r_aborted;
    words_done = r_index;
    DMAEn      = w_inRequest;
    DMAWrEn    = (r_state == WR_REQ);
    DMAAddr    = '0;
    DMAData    = '0;
    if (r_state == RD_REQ) begin
      DMAAddr = r_srcAddr + w_indexAddr;
    end else if (r_state == WR_REQ) begin
      DMAAddr = r_dstAddr + w_indexAddr;
      DMAData = r_buffer;
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: a memory-controller responder with stalls, a directed
// vector table and randomized copies checked against a word-by-word copy model.
module tb_dma_copy_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] words_done;
  logic        DMAEn;
  logic        DMAWrEn;
  logic [15:0] DMAAddr;
  logic [31:0] DMAData;
  logic [31:0] DMAOut;
  logic        DMAValid;

  dma_copy_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .DMAEn(DMAEn), .DMAWrEn(DMAWrEn), .DMAAddr(DMAAddr), .DMAData(DMAData),
    .DMAOut(DMAOut), .DMAValid(DMAValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    int          abortMode;
    int          abortIdx;
    int          stallRead;
    int          stallLen;
    int          lateStartAt;
    bit          startWithAbort;
    int          expWords;
    int          expDone;
    int          expBusy;
    int          expAborted;
    int          expReads;
  } copyVec_t;

  typedef struct {
    int doneCycle;
    int doneCount;
    int busyCycles;
    int abortedCount;
    int enAfterAbort;
    int extraActivity;
    int timeout;
  } copyObs_t;

  localparam int BUDGET = 300;
  localparam int NVEC   = 9;
  localparam int NRAND  = 20;

  logic [31:0] mem    [0:65535];
  logic [31:0] shadow [0:65535];
  logic [15:0] rdLog[$];
  logic [15:0] wrLog[$];

  int          checks;
  int          failures;
  int          stallRead;
  int          stallLeft;
  int          stallCount;
  int          stabViol;
  bit          randMode;
  bit          prevPending;
  bit          prevWr;
  logic [15:0] prevAddr;
  logic [31:0] prevData;
  copyVec_t    vecs [NVEC];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Memory controller stand-in: services DMAEn the same cycle unless a stall is scheduled.
  task automatic serviceMem();
    if (!rst_n) begin
      DMAValid    = 1'b0;
      DMAOut      = '0;
      prevPending = 1'b0;
      return;
    end
    if (prevPending && DMAEn &&
        (DMAWrEn !== prevWr || DMAAddr !== prevAddr || (DMAWrEn && DMAData !== prevData))) begin
      stabViol++;
    end
    DMAOut = $urandom;
    if (DMAEn) begin
      DMAValid = 1'b1;
      if (!DMAWrEn && rdLog.size() == stallRead && stallLeft > 0) begin
        DMAValid = 1'b0;
        stallLeft--;
      end else if (randMode && $urandom_range(0, 2) == 0) begin
        DMAValid = 1'b0;
      end
      if (!DMAValid) stallCount++;
    end else begin
      DMAValid = randMode && ($urandom_range(0, 1) == 1);
    end
    if (DMAEn && DMAValid) begin
      if (DMAWrEn) begin
        mem[DMAAddr] = DMAData;
        wrLog.push_back(DMAAddr);
      end else begin
        DMAOut = mem[DMAAddr];
        rdLog.push_back(DMAAddr);
      end
    end
    prevPending = DMAEn && !DMAValid;
    prevWr      = DMAWrEn;
    prevAddr    = DMAAddr;
    prevData    = DMAData;
  endtask

  task automatic cycle();
    @(negedge clk);
    serviceMem();
  endtask

  task automatic applyStimulus(input copyVec_t v, output copyObs_t o);
    bit finished;
    o = '{default: 0};
    o.doneCycle = -1;
    finished    = 1'b0;
    rdLog.delete();
    wrLog.delete();
    stallRead  = v.stallRead;
    stallLeft  = v.stallLen;
    stallCount = 0;
    stabViol   = 0;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = v.len;
    start    = 1'b1;
    abort    = v.startWithAbort;
    for (int n = 1; n <= BUDGET; n++) begin
      cycle();
      start    = 1'b0;
      abort    = 1'b0;
      src_addr = 16'($urandom);
      dst_addr = 16'($urandom);
      len      = 16'($urandom_range(0, 3));
      if (busy) o.busyCycles++;
      if (done) begin
        o.doneCount++;
        if (o.doneCycle < 0) o.doneCycle = n;
      end
      if (aborted) begin
        o.abortedCount++;
        o.enAfterAbort = int'(DMAEn) + int'(busy);
      end
      if (n == v.lateStartAt && !aborted) start = 1'b1;
      if (v.abortMode == 1 && DMAEn && DMAWrEn && DMAValid && wrLog.size() == v.abortIdx + 1)
        abort = 1'b1;
      if (v.abortMode == 2 && DMAEn && !DMAWrEn && !DMAValid && rdLog.size() == v.abortIdx)
        abort = 1'b1;
      if (done || aborted) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) o.timeout = 1;
    repeat (2) begin
      cycle();
      start = 1'b0;
      abort = 1'b0;
      o.extraActivity += int'(DMAEn) + int'(busy) + int'(done) + int'(aborted);
    end
  endtask

  task automatic checkOutput(input int id, input copyVec_t v, input copyObs_t o);
    string tag;
    int    diffs;
    int    addrErr;
    tag = $sformatf("copy%0d", id);
    for (int i = 0; i < v.expWords; i++) shadow[v.dst + 16'(i)] = shadow[v.src + 16'(i)];
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== shadow[i]) diffs++;
    check({tag, ".memDiffWords"}, diffs, 0);
    check({tag, ".words_done"}, words_done, v.expWords);
    check({tag, ".writeCount"}, wrLog.size(), v.expWords);
    addrErr = 0;
    foreach (wrLog[i]) if (wrLog[i] !== v.dst + 16'(i)) addrErr++;
    check({tag, ".writeAddrErr"}, addrErr, 0);
    check({tag, ".readCount"}, rdLog.size(), v.expReads);
    addrErr = 0;
    foreach (rdLog[i]) if (rdLog[i] !== v.src + 16'(i)) addrErr++;
    check({tag, ".readAddrErr"}, addrErr, 0);
    check({tag, ".doneCycle"}, o.doneCycle, v.expDone);
    check({tag, ".doneCount"}, o.doneCount, (v.expDone >= 0) ? 1 : 0);
    check({tag, ".busyCycles"}, o.busyCycles, v.expBusy);
    check({tag, ".abortedCount"}, o.abortedCount, v.expAborted);
    check({tag, ".busyOrEnAtAborted"}, o.enAfterAbort, 0);
    check({tag, ".activityAfterEnd"}, o.extraActivity, 0);
    check({tag, ".timeout"}, o.timeout, 0);
    check({tag, ".requestUnstable"}, stabViol, 0);
  endtask

  initial begin
    copyVec_t v;
    copyObs_t o;
    bit       found;
    int       w;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    DMAOut = '0; DMAValid = 1'b0;
    randMode = 1'b0; stallRead = -1; stallLeft = 0; stallCount = 0; stabViol = 0;
    prevPending = 1'b0; prevWr = 1'b0; prevAddr = '0; prevData = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16'h0010 + 16'(i)]    = 32'hA000_0000 + 32'(i);
      shadow[16'h0010 + 16'(i)] = 32'hA000_0000 + 32'(i);
    end

    //         src       dst       len  mode idx stRd stLen late swa words done busy abt reads
    vecs[0] = '{16'h0010, 16'h0100, 16'd4, 0, 0, -1, 0, 0, 1'b0, 4, 9, 8, 0, 4};
    vecs[1] = '{16'h0000, 16'h0200, 16'd0, 0, 0, -1, 0, 1, 1'b0, 0, 1, 0, 0, 0};
    vecs[2] = '{16'hFFFE, 16'h7FFE, 16'd4, 0, 0, -1, 0, 0, 1'b0, 4, 9, 8, 0, 4};
    vecs[3] = '{16'h0020, 16'h0300, 16'd4, 0, 0, 1, 3, 0, 1'b0, 4, 12, 11, 0, 4};
    vecs[4] = '{16'h0040, 16'h0400, 16'd8, 1, 2, -1, 0, 3, 1'b0, 3, -1, 6, 1, 3};
    vecs[5] = '{16'h0050, 16'h0500, 16'd5, 2, 2, 2, 3, 0, 1'b0, 2, -1, 5, 1, 2};
    vecs[6] = '{16'h0060, 16'h0600, 16'd2, 0, 0, -1, 0, 0, 1'b1, 2, 5, 4, 0, 2};
    vecs[7] = '{16'h0070, 16'h0700, 16'd1, 0, 0, -1, 0, 3, 1'b0, 1, 3, 2, 0, 1};
    vecs[8] = '{16'h0080, 16'h0081, 16'd3, 0, 0, -1, 0, 0, 1'b0, 3, 7, 6, 0, 3};

    repeat (2) @(negedge clk);
    check("reset.ctrl", {busy, done, aborted, DMAEn, DMAWrEn}, 0);
    check("reset.DMAAddr", DMAAddr, 0);
    check("reset.DMAData", DMAData, 0);
    check("reset.words_done", words_done, 0);
    rst_n = 1'b1;
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();
    check("idleAbort.ignored", {aborted, busy, DMAEn}, 0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], o);
      checkOutput(i, vecs[i], o);
    end

    // Reset asserted while the second read is outstanding; one word has already landed.
    rdLog.delete(); wrLog.delete(); stallRead = -1;
    src_addr = 16'h0090; dst_addr = 16'h0900; len = 16'd4; start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cycle();
      start = 1'b0;
      if (DMAEn && !DMAWrEn && wrLog.size() == 1) begin
        found = 1'b1;
        break;
      end
    end
    check("midReset.reachedRead2", found, 1);
    rst_n = 1'b0;
    DMAValid = 1'b0;
    #1;
    check("midReset.ctrl", {busy, done, aborted, DMAEn, DMAWrEn}, 0);
    check("midReset.DMAAddr", DMAAddr, 0);
    check("midReset.DMAData", DMAData, 0);
    check("midReset.words_done", words_done, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("midReset.noPulse", {done, aborted, busy}, 0);
    shadow[16'h0900] = shadow[16'h0090];
    v = '{16'h0090, 16'h0900, 16'd4, 0, 0, -1, 0, 0, 1'b0, 4, 9, 8, 0, 4};
    applyStimulus(v, o);
    checkOutput(100, v, o);

    randMode = 1'b1;
    for (int r = 0; r < NRAND; r++) begin
      v = '{default: 0};
      v.src       = 16'($urandom);
      v.dst       = 16'($urandom);
      v.len       = 16'($urandom_range(0, 12));
      v.stallRead = -1;
      v.lateStartAt = $urandom_range(0, 6);
      v.startWithAbort = ($urandom_range(0, 3) == 0);
      if (v.len > 0 && $urandom_range(0, 2) == 0) begin
        v.abortMode = 1;
        v.abortIdx  = $urandom_range(0, int'(v.len) - 1);
      end
      applyStimulus(v, o);
      w = (v.abortMode == 1) ? v.abortIdx + 1 : int'(v.len);
      v.expWords   = w;
      v.expReads   = w;
      v.expBusy    = 2 * w + stallCount;
      v.expAborted = (v.abortMode == 1) ? 1 : 0;
      v.expDone    = (v.abortMode == 1) ? -1 : v.expBusy + 1;
      checkOutput(200 + r, v, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
